// File: rtl/backprop_sequencer.sv
// Epoch-level sequencer for the backpropagation datapath. For each sample it issues
// the sample index once and layer tokens LAYER_MAX..1, then waits for one weight update per layer.
module backprop_sequencer #(
    parameter int LAYER_ADDR_WIDTH = 2,
    parameter int LAYER_MAX        = 3,
    parameter int SAMPLE_ADDR_SIZE = 10,
    parameter int SAMPLE_COUNT     = 1000,
    parameter int EPOCH_WIDTH      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_valid,
    output logic                        start_ready,
    input  logic                        stop,
    output logic [LAYER_ADDR_WIDTH-1:0] layer,
    output logic                        layer_valid,
    input  logic                        layer_ready,
    output logic [SAMPLE_ADDR_SIZE-1:0] sample,
    output logic                        sample_valid,
    input  logic                        sample_ready,
    input  logic                        weights_valid,
    input  logic                        weights_ready,
    input  logic                        bp_error,
    output logic                        busy,
    output logic                        done,
    output logic [EPOCH_WIDTH-1:0]      epoch_count,
    output logic                        error_sticky
);

    // state  | meaning
    // IDLE   | waiting for start_valid
    // ISSUE  | sending the sample index and layer tokens of the current sample
    // DRAIN  | all tokens sent, waiting for LAYER_MAX weight updates
    // DONE   | one-cycle epoch-end pulse
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic [LAYER_ADDR_WIDTH-1:0] LAYER_TOP   = LAYER_ADDR_WIDTH'(LAYER_MAX);
    localparam logic [SAMPLE_ADDR_SIZE-1:0] LAST_SAMPLE = SAMPLE_ADDR_SIZE'(SAMPLE_COUNT - 1);

    state_t                        state;
    state_t                        state_nxt;
    logic [LAYER_ADDR_WIDTH-1:0]   layer_cnt;
    logic [LAYER_ADDR_WIDTH-1:0]   wb_cnt;
    logic [LAYER_ADDR_WIDTH-1:0]   wb_cnt_nxt;
    logic [SAMPLE_ADDR_SIZE-1:0]   sample_idx;
    logic                          sample_sent;
    logic                          busy_q;
    logic                          done_q;
    logic [EPOCH_WIDTH-1:0]        epoch_q;
    logic                          err_q;

    logic                          in_flight;
    logic                          layer_hs;
    logic                          sample_hs;
    logic                          wb_hs;
    logic                          wb_full;
    logic                          tokens_done;
    logic                          sent_done;
    logic                          start_acc;
    logic                          next_sample;

    assign in_flight    = (state == ST_ISSUE) || (state == ST_DRAIN);
    assign layer_valid  = (state == ST_ISSUE) && (layer_cnt != '0);
    assign sample_valid = (state == ST_ISSUE) && !sample_sent;
    assign layer_hs     = layer_valid && layer_ready;
    assign sample_hs    = sample_valid && sample_ready;

    // Weight updates are only counted while a sample is in flight; the count saturates.
    assign wb_hs      = in_flight && weights_valid && weights_ready;
    assign wb_cnt_nxt = (wb_hs && (wb_cnt != LAYER_TOP)) ? wb_cnt + 1'b1 : wb_cnt;
    assign wb_full    = (wb_cnt_nxt == LAYER_TOP);

    assign tokens_done = (layer_cnt == '0) || (layer_hs && (layer_cnt == 1));
    assign sent_done   = sample_sent || sample_hs;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        start_ready = 1'b0;
        start_acc   = 1'b0;
        next_sample = 1'b0;
        case (state)
            ST_IDLE: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    start_acc = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (tokens_done && sent_done) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (wb_full) begin
                    if ((sample_idx == LAST_SAMPLE) || stop) begin
                        state_nxt = ST_DONE;
                    end else begin
                        next_sample = 1'b1;
                        state_nxt   = ST_ISSUE;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            layer_cnt   <= '0;
            wb_cnt      <= '0;
            sample_idx  <= '0;
            sample_sent <= 1'b0;
        end else if (start_acc) begin
            layer_cnt   <= LAYER_TOP;
            wb_cnt      <= '0;
            sample_idx  <= '0;
            sample_sent <= 1'b0;
        end else if (next_sample) begin
            layer_cnt   <= LAYER_TOP;
            wb_cnt      <= '0;
            sample_idx  <= sample_idx + 1'b1;
            sample_sent <= 1'b0;
        end else begin
            if (layer_hs) begin
                layer_cnt <= layer_cnt - 1'b1;
            end
            if (sample_hs) begin
                sample_sent <= 1'b1;
            end
            wb_cnt <= wb_cnt_nxt;
        end
    end

    // An error arriving in the same cycle as the start is kept rather than cleared.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q   <= 1'b0;
            epoch_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            if (start_acc) begin
                err_q <= bp_error;
            end else if (bp_error) begin
                err_q <= 1'b1;
            end
            if (state == ST_DONE) begin
                epoch_q <= epoch_q + 1'b1;
            end
            busy_q <= (state_nxt != ST_IDLE);
            done_q <= (state_nxt == ST_DONE);
        end
    end

    assign layer        = layer_cnt;
    assign sample       = sample_idx;
    assign busy         = busy_q;
    assign done         = done_q;
    assign epoch_count  = epoch_q;
    assign error_sticky = err_q;

endmodule

// File: tb/tb_backprop_sequencer.sv
// Directed bench for backprop_sequencer (LAYER_MAX=3, SAMPLE_COUNT=2) with a
// datapath model that returns one weight update two cycles after each accepted token.
module tb_backprop_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_valid;
    logic        start_ready;
    logic        stop;
    logic [1:0]  layer;
    logic        layer_valid;
    logic        layer_ready;
    logic [9:0]  sample;
    logic        sample_valid;
    logic        sample_ready;
    logic        weights_valid;
    logic        weights_ready;
    logic        bp_error;
    logic        busy;
    logic        done;
    logic [15:0] epoch_count;
    logic        error_sticky;

    backprop_sequencer #(
        .LAYER_ADDR_WIDTH(2),
        .LAYER_MAX(3),
        .SAMPLE_ADDR_SIZE(10),
        .SAMPLE_COUNT(2),
        .EPOCH_WIDTH(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .stop(stop),
        .layer(layer),
        .layer_valid(layer_valid),
        .layer_ready(layer_ready),
        .sample(sample),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .weights_valid(weights_valid),
        .weights_ready(weights_ready),
        .bp_error(bp_error),
        .busy(busy),
        .done(done),
        .epoch_count(epoch_count),
        .error_sticky(error_sticky)
    );

    always #5 clk = ~clk;

    int   n_chk = 0;
    int   n_pass = 0;
    int   tok_q[$];
    int   smp_q[$];
    int   done_cnt;
    int   whs_cnt;
    logic [1:0] wpipe;
    bit   lr_toggle;
    bit   stab_chk;
    int   sr_hold;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // One clock: capture handshakes before the edge, update the model and drive after it.
    task automatic step();
        logic lv, lr, lhs, shs, whs, d;
        int   lval, sval;
        lv   = layer_valid;
        lr   = layer_ready;
        lhs  = lv && lr;
        shs  = sample_valid && sample_ready;
        whs  = weights_valid && weights_ready;
        d    = done;
        lval = int'(layer);
        sval = int'(sample);
        @(posedge clk);
        #1;
        if (lhs) tok_q.push_back(lval);
        if (shs) smp_q.push_back(sval);
        if (d) done_cnt++;
        if (whs) whs_cnt++;
        if (stab_chk && lv && !lr && rst) begin
            check("layer_hold_valid", int'(layer_valid), 1);
            check("layer_hold_value", int'(layer), lval);
        end
        wpipe = {wpipe[0], lhs};
        weights_valid = wpipe[1];
        if (lr_toggle) layer_ready = !layer_ready;
        if (sr_hold > 0) begin
            sr_hold--;
            sample_ready = (sr_hold == 0);
        end
    endtask

    task automatic start_epoch();
        tok_q.delete();
        smp_q.delete();
        done_cnt = 0;
        whs_cnt = 0;
        start_valid = 1'b1;
        step();
        start_valid = 1'b0;
    endtask

    task automatic run_to_done(input string tag);
        for (int k = 0; k < 400 && done_cnt == 0; k++) step();
        check({tag, "_done_seen"}, done_cnt, 1);
        check({tag, "_idle_after"}, int'(start_ready), 1);
    endtask

    task automatic check_tokens(input string tag, input int n);
        int got;
        check({tag, "_ntok"}, tok_q.size(), n);
        check({tag, "_nsmp"}, smp_q.size(), n / 3);
        for (int i = 0; i < n; i++) begin
            got = (i < tok_q.size()) ? tok_q[i] : -1;
            check({tag, "_tok"}, got, 3 - (i % 3));
        end
        for (int j = 0; j < n / 3; j++) begin
            got = (j < smp_q.size()) ? smp_q[j] : -1;
            check({tag, "_smp"}, got, j);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_layer_valid"}, int'(layer_valid), 0);
        check({tag, "_sample_valid"}, int'(sample_valid), 0);
        check({tag, "_layer"}, int'(layer), 0);
        check({tag, "_sample"}, int'(sample), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_epoch"}, int'(epoch_count), 0);
        check({tag, "_err"}, int'(error_sticky), 0);
        check({tag, "_start_ready"}, int'(start_ready), 1);
    endtask

    initial begin
        bit found;
        rst = 1'b0;
        start_valid = 1'b0;
        stop = 1'b0;
        layer_ready = 1'b1;
        sample_ready = 1'b1;
        weights_valid = 1'b0;
        weights_ready = 1'b1;
        bp_error = 1'b0;
        wpipe = 2'b00;
        lr_toggle = 1'b0;
        stab_chk = 1'b0;
        sr_hold = 0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst = 1'b1;
        step();

        // Ready tied high: two full samples
        start_epoch();
        check("t1_lv", int'(layer_valid), 1);
        check("t1_sv", int'(sample_valid), 1);
        check("t1_layer0", int'(layer), 3);
        check("t1_busy", int'(busy), 1);
        check("t1_start_ready", int'(start_ready), 0);
        repeat (3) step();
        check("t1_drain_lv", int'(layer_valid), 0);
        check("t1_drain_sv", int'(sample_valid), 0);
        check("t1_drain_busy", int'(busy), 1);
        run_to_done("t1");
        check_tokens("t1", 6);
        check("t1_epoch", int'(epoch_count), 1);
        check("t1_done_low", int'(done), 0);
        check("t1_busy_low", int'(busy), 0);

        // sample_ready held low after start
        sample_ready = 1'b0;
        sr_hold = 5;
        start_epoch();
        repeat (3) step();
        check("t2_lv_off", int'(layer_valid), 0);
        check("t2_sv_hold", int'(sample_valid), 1);
        check("t2_sample0", int'(sample), 0);
        check("t2_ntok3", tok_q.size(), 3);
        step();
        check("t2_sv_still", int'(sample_valid), 1);
        step();
        check("t2_sv_accepted", int'(sample_valid), 0);
        check("t2_nsmp1", smp_q.size(), 1);
        run_to_done("t2");
        check_tokens("t2", 6);
        check("t2_epoch", int'(epoch_count), 2);

        // layer_ready toggling
        lr_toggle = 1'b1;
        stab_chk = 1'b1;
        start_epoch();
        run_to_done("t3");
        lr_toggle = 1'b0;
        stab_chk = 1'b0;
        layer_ready = 1'b1;
        check_tokens("t3", 6);
        check("t3_epoch", int'(epoch_count), 3);

        // stop during sample 0
        start_epoch();
        stop = 1'b1;
        run_to_done("t4");
        stop = 1'b0;
        check_tokens("t4", 3);
        check("t4_whs", whs_cnt, 3);
        check("t4_epoch", int'(epoch_count), 4);

        // bp_error pulse mid-epoch
        start_epoch();
        repeat (2) step();
        check("t5_err_before", int'(error_sticky), 0);
        bp_error = 1'b1;
        step();
        bp_error = 1'b0;
        check("t5_err_set", int'(error_sticky), 1);
        run_to_done("t5");
        check_tokens("t5", 6);
        check("t5_err_done", int'(error_sticky), 1);
        step();
        check("t5_err_idle", int'(error_sticky), 1);
        check("t5_epoch", int'(epoch_count), 5);

        // reset in DRAIN of sample 1
        start_epoch();
        check("t6_err_cleared", int'(error_sticky), 0);
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            step();
            if (smp_q.size() == 2 && !layer_valid && !sample_valid && busy) found = 1'b1;
        end
        check("t6_drain_found", int'(found), 1);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("t6_async");
        repeat (2) step();
        wpipe = 2'b00;
        weights_valid = 1'b0;
        rst = 1'b1;
        step();
        check("t6_epoch_kept0", int'(epoch_count), 0);
        start_epoch();
        check("t6_restart_layer", int'(layer), 3);
        check("t6_restart_sample", int'(sample), 0);
        check("t6_restart_lv", int'(layer_valid), 1);
        check("t6_restart_sv", int'(sample_valid), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
